if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage: the receiving end of the PC generator's `pc`/`new_sign` output.
- Accepts a fetch PC, issues a single-outstanding read on the instruction-memory request/response channel, and extracts the 32-bit instruction from the 64-bit beat.
- Presents {inst, pc, exc} to decode with a valid/ready handshake.
- Drives `pc_stall_o` back to the PC generator and discards in-flight fetches on redirect (flush).

Parameters:
PC_W, 64, fetch address width
INST_W, 32, instruction width
BUS_W, 64, instruction-memory data width
NOP_INST, 32'h00000013, instruction emitted on exception

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
pc_i  in  PC_W  fetch PC from the PC generator
new_sign_i  in  1  pc_i is a new PC to fetch this cycle
flush_i  in  1  redirect from ID/EX; kill current fetch
pc_stall_o  out  1  1 = PC generator must hold pc
imem_req_valid_o  out  1  read request valid
imem_req_ready_i  in  1  memory accepts request
imem_req_addr_o  out  PC_W  8-byte-aligned read address
imem_resp_valid_i  in  1  read data valid
imem_resp_data_i  in  BUS_W  read data
imem_resp_err_i  in  1  bus error on this response
if_valid_o  out  1  instruction valid to decode
id_ready_i  in  1  decode accepts instruction
if_inst_o  out  INST_W  instruction
if_pc_o  out  PC_W  PC of if_inst_o
if_exc_o  out  1  fetch exception (misaligned or bus error)

Behaviour:
- Reset: clk, synchronous active-low `rst`; rst==0 at posedge forces:
  - state=IDLE, drop flag=0
  - all registered outputs 0: if_valid_o, if_inst_o, if_pc_o, if_exc_o, imem_req_valid_o, imem_req_addr_o
  - Reset overrides every other input, including mid-transaction. A response arriving in IDLE is ignored.
- pc_stall_o = (state != IDLE); combinational from state.
- State machine, one request outstanding max:
  - IDLE:
    - flush_i=1 → stay IDLE; pc_i is discarded (wrong path).
    - Else new_sign_i=1 → latch pc_i into pc_q.
      - pc_q[1:0]!=0 → OUT with inst=NOP_INST, exc=1; no bus request.
      - Otherwise → REQ.
  - REQ:
    - imem_req_valid_o=1, imem_req_addr_o={pc_q[PC_W-1:3],3'b0}.
    - Valid and addr stay stable until imem_req_ready_i.
    - Handshake → WAIT, or → DROP if the drop flag is set.
    - flush_i in REQ sets the drop flag; the request is never withdrawn.
  - WAIT:
    - imem_resp_valid_i → capture: inst = pc_q[2] ? data[63:32] : data[31:0]; exc = imem_resp_err_i; if exc, inst=NOP_INST.
    - → OUT.
    - flush_i without resp → DROP.
    - flush_i with resp in the same cycle → response discarded, → IDLE.
  - DROP: wait for imem_resp_valid_i, discard it, → IDLE; clear the drop flag. flush_i has no further effect.
  - OUT:
    - if_valid_o=1; if_inst_o/if_pc_o/if_exc_o are stable while id_ready_i=0.
    - id_ready_i=1 → if_valid_o=0 next cycle, → IDLE.
    - flush_i (priority over id_ready_i) → if_valid_o=0 next cycle, → IDLE.
- Latency, zero-wait memory:
  - new_sign_i at cycle 0
  - req valid cycle 1 (accepted cycle 1)
  - resp cycle 2
  - if_valid_o cycle 3
  - Misaligned PC: if_valid_o at cycle 1.
- Throughput: max one instruction per 4 cycles. No prefetch; OUT→IDLE costs one cycle.
- `new_sign_i` outside IDLE is ignored; the PC generator holds `pc` because `pc_stall_o=1`.
- if_valid_o never asserts for a fetch that saw flush_i at any point after acceptance.

Test Plan:
- Aligned fetch:
  - Stimulus: pc_i=0x80000004, new_sign_i=1, ready=1, memory responds next cycle with data=0x00500093_00000013.
  - Required: req addr 0x80000000; if_inst_o=0x00500093, if_pc_o=0x80000004, if_exc_o=0, if_valid_o high at cycle 3; pc_stall_o=1 cycles 1-3.
- Misaligned:
  - Stimulus: pc_i=0x80000002.
  - Required: no imem_req_valid_o; if_valid_o=1 next cycle with if_inst_o=0x00000013, if_exc_o=1.
- Backpressure:
  - Stimulus: imem_req_ready_i=0 for 3 cycles, then id_ready_i=0 for 4 cycles after output.
  - Required: req valid/addr stable all 3 cycles; if outputs stable and if_valid_o held 4 cycles; IDLE one cycle after id_ready_i=1.
- Flush in WAIT:
  - Stimulus: flush_i pulses 1 cycle after request accept; response 3 cycles later with 0xDEADBEEF.
  - Required: if_valid_o never asserts; state returns IDLE after response; next new_sign_i fetches normally.
- Flush and response same cycle, plus bus error:
  - Stimulus: flush_i and resp in the same cycle.
  - Required: no output.
  - Stimulus: a following fetch with imem_resp_err_i=1.
  - Required: if_exc_o=1, if_inst_o=NOP.
- Reset mid-WAIT:
  - Stimulus: rst=0 for one cycle while in WAIT.
  - Required: all outputs 0, pc_stall_o=0 next cycle; a stale response then arriving is ignored.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: takes a PC from the PC generator, performs one
// outstanding 64-bit instruction-memory read and hands {inst, pc, exc} to decode.
module if_fetch #(
  parameter int                PC_W     = 64,
  parameter int                INST_W   = 32,
  parameter int                BUS_W    = 64,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              new_sign_i,
  input  logic              flush_i,
  output logic              pc_stall_o,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [BUS_W-1:0]  imem_resp_data_i,
  input  logic              imem_resp_err_i,
  output logic              if_valid_o,
  input  logic              id_ready_i,
  output logic [INST_W-1:0] if_inst_o,
  output logic [PC_W-1:0]   if_pc_o,
  output logic              if_exc_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, OUT} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc_q;
  logic              drop;
  logic [INST_W-1:0] beat_inst;

  assign pc_stall_o = (state != IDLE);

  // pc_q[2] picks the upper or lower half of the aligned 64-bit beat
  assign beat_inst = pc_q[2] ? imem_resp_data_i[2*INST_W-1:INST_W]
                             : imem_resp_data_i[INST_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      drop             <= 1'b0;
      pc_q             <= '0;
      imem_req_valid_o <= 1'b0;
      imem_req_addr_o  <= '0;
      if_valid_o       <= 1'b0;
      if_inst_o        <= '0;
      if_pc_o          <= '0;
      if_exc_o         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!flush_i && new_sign_i) begin
            pc_q <= pc_i;
            if (pc_i[1:0] != 2'b00) begin
              // misaligned PC never reaches the bus
              state      <= OUT;
              if_valid_o <= 1'b1;
              if_inst_o  <= NOP_INST;
              if_pc_o    <= pc_i;
              if_exc_o   <= 1'b1;
            end else begin
              state            <= REQ;
              imem_req_valid_o <= 1'b1;
              imem_req_addr_o  <= {pc_i[PC_W-1:3], 3'b000};
            end
          end
        end
        REQ: begin
          // a request once raised is never withdrawn; a flush only marks it dead
          if (flush_i) drop <= 1'b1;
          if (imem_req_ready_i) begin
            imem_req_valid_o <= 1'b0;
            state            <= (drop || flush_i) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid_i) begin
            if (flush_i) begin
              state <= IDLE;
            end else begin
              state      <= OUT;
              if_valid_o <= 1'b1;
              if_pc_o    <= pc_q;
              if_exc_o   <= imem_resp_err_i;
              if_inst_o  <= imem_resp_err_i ? NOP_INST : beat_inst;
            end
          end else if (flush_i) begin
            drop  <= 1'b1;
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_resp_valid_i) begin
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        OUT: begin
          if (flush_i || id_ready_i) begin
            if_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
